// File: rtl/reimu_bullet_pkg.sv
// Shared boss-stage constants and the player shot engine state encoding.
// Boss HP and hitbox sizes are also used by the boss sprite and boss_bullet.
package reimu_bullet_pkg;
    localparam int P_X_MIN   = 8;
    localparam int P_X_MAX   = 432;
    localparam int P_Y_MIN   = 8;
    localparam int P_Y_MAX   = 472;

    localparam int P_BOSS_HP = 100;
    localparam int P_HIT_HW  = 24;
    localparam int P_HIT_HH  = 24;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIGHT    = 2'd1,
        DEFEATED = 2'd2
    } state_t;
endpackage

// File: rtl/reimu_bullet_slot.sv
// One player bullet: position/valid registers, upward move, boss hitbox test
// and top-of-playfield exit.
module bullet_slot
    import reimu_bullet_pkg::*;
#(
    parameter int SPEED  = 12,
    parameter int HIT_HW = P_HIT_HW,
    parameter int HIT_HH = P_HIT_HH,
    parameter int TOP_Y  = P_Y_MIN
) (
    input  logic       clk22,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic [9:0] i_ld_x,
    input  logic [9:0] i_ld_y,
    input  logic [9:0] i_bossx,
    input  logic [9:0] i_bossy,
    output logic       o_valid,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_hit
);
    logic       r_valid;
    logic [9:0] r_x, r_y;
    logic [10:0] w_bx, w_by, w_cx, w_cy;
    logic        w_overlap, w_exit;

    // 11-bit compares so centre +/- half-size never wraps
    assign w_bx = {1'b0, r_x};
    assign w_by = {1'b0, r_y};
    assign w_cx = {1'b0, i_bossx};
    assign w_cy = {1'b0, i_bossy};

    assign w_overlap = (w_bx + 11'(HIT_HW) > w_cx) && (w_bx < w_cx + 11'(HIT_HW)) &&
                       (w_by + 11'(HIT_HH) > w_cy) && (w_by < w_cy + 11'(HIT_HH));
    assign w_exit    = w_by < 11'(TOP_Y + SPEED);
    assign o_hit     = r_valid && w_overlap;

    always_ff @(posedge clk22) begin
        if (i_clr) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_x     <= i_ld_x;
            r_y     <= i_ld_y;
        end else if (r_valid) begin
            if (o_hit || w_exit) begin
                r_valid <= 1'b0;
                r_x     <= '0;
                r_y     <= '0;
            end else begin
                r_y <= r_y - 10'(SPEED);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_x     = r_x;
    assign o_y     = r_y;
endmodule

// File: rtl/reimu_bullet.sv
// Player shot engine for the boss stage: bullet pool allocator, fire cooldown,
// boss HP counter and IDLE/FIGHT/DEFEATED control.
module reimu_bullet
    import reimu_bullet_pkg::*;
#(
    parameter int NSLOT    = 4,
    parameter int SPEED    = 12,
    parameter int COOLDOWN = 4,
    parameter int BOSS_HP  = P_BOSS_HP,
    parameter int HIT_HW   = P_HIT_HW,
    parameter int HIT_HH   = P_HIT_HH,
    parameter int TOP_Y    = P_Y_MIN
) (
    input  logic                  clk22,
    input  logic                  rst,
    input  logic                  gamestart,
    input  logic                  boss,
    input  logic                  fire,
    input  logic [9:0]            reimux,
    input  logic [9:0]            reimuy,
    input  logic [9:0]            bossx,
    input  logic [9:0]            bossy,
    output logic [NSLOT-1:0]      bullet_valid,
    output logic [10*NSLOT-1:0]   bullet_x,
    output logic [10*NSLOT-1:0]   bullet_y,
    output logic                  boss_hit,
    output logic [7:0]            boss_hp,
    output logic                  boss_defeated
);
    state_t           r_state, w_state_nxt;
    logic [7:0]       r_cd, r_hp, w_nhit, w_hp_dec;
    logic [NSLOT-1:0] w_hit, w_load;
    logic [9:0]       w_ld_y;
    logic             w_sync_clr, w_any_free, w_spawn, w_in_fight, w_slot_clr, w_reload;

    assign w_sync_clr = rst || gamestart;
    assign w_ld_y     = reimuy - 10'd16;

    always_ff @(posedge clk22) begin
        if (w_sync_clr) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (boss) w_state_nxt = FIGHT;
            FIGHT:    if (!boss) w_state_nxt = IDLE;
                      else if (w_nhit != 8'd0 && w_hp_dec == 8'd0) w_state_nxt = DEFEATED;
            DEFEATED: if (!boss) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Slots only live while we stay in FIGHT; leaving it (drop or defeat) wipes them
    always_comb begin
        boss_defeated = (r_state == DEFEATED);
        w_in_fight    = (r_state == FIGHT) && (w_state_nxt == FIGHT);
        w_slot_clr    = w_sync_clr || !w_in_fight;
        w_reload      = (w_state_nxt == IDLE);
    end

    // Lowest free slot from registered flags only
    always_comb begin
        w_load     = '0;
        w_any_free = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (!bullet_valid[i] && !w_any_free) begin
                w_load[i]  = 1'b1;
                w_any_free = 1'b1;
            end
        end
        w_spawn = w_in_fight && fire && (r_cd == 8'd0) && w_any_free;
    end

    always_comb begin
        w_nhit = '0;
        for (int i = 0; i < NSLOT; i++) w_nhit = w_nhit + 8'(w_hit[i]);
        w_hp_dec = (w_nhit >= r_hp) ? 8'd0 : r_hp - w_nhit;
    end

    always_ff @(posedge clk22) begin
        if (w_sync_clr) begin
            r_cd     <= '0;
            r_hp     <= 8'(BOSS_HP);
            boss_hit <= 1'b0;
        end else begin
            if (w_spawn)            r_cd <= 8'(COOLDOWN);
            else if (r_cd != 8'd0)  r_cd <= r_cd - 8'd1;
            boss_hit <= (r_state == FIGHT) && (w_nhit != 8'd0);
            if (w_reload)              r_hp <= 8'(BOSS_HP);
            else if (r_state == FIGHT) r_hp <= w_hp_dec;
        end
    end

    assign boss_hp = r_hp;

    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        bullet_slot #(
            .SPEED (SPEED),
            .HIT_HW(HIT_HW),
            .HIT_HH(HIT_HH),
            .TOP_Y (TOP_Y)
        ) u_slot (
            .clk22  (clk22),
            .i_clr  (w_slot_clr),
            .i_load (w_spawn && w_load[gi]),
            .i_ld_x (reimux),
            .i_ld_y (w_ld_y),
            .i_bossx(bossx),
            .i_bossy(bossy),
            .o_valid(bullet_valid[gi]),
            .o_x    (bullet_x[10*gi +: 10]),
            .o_y    (bullet_y[10*gi +: 10]),
            .o_hit  (w_hit[gi])
        );
    end
endmodule
